reward_manager: RTL

Parametrised successor of the single-counter reward logic in the tank game: tracks up to NUM_REWARDS power-ups, each with its own independent countdown timer. Arbitrates pickup of the single on-map reward offered by the random generator, acknowledges it with a one-cycle handshake, and exposes per-reward active flags plus a selectable remaining-time readout for the information overlay. Sits between the reward random generator, the tank position logic, and the VGA reward/information renderers. All timing runs in the `clk` domain; the 4 Hz game tick is a clock-enable pulse, not a clock.

---
 rtl/reward_manager.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/reward_manager.sv
// Timed power-up manager: arbitrates pickup of the single on-map reward offer and
// runs one independent countdown per reward type on the 4 Hz game tick.
module reward_manager #(
    parameter int NUM_REWARDS = 5,
    parameter int TYPE_W      = 3,
    parameter int GRID_W      = 5,
    parameter int CNT_W       = 8,
    parameter int DURATION    = 20,
    parameter int STACK_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   mode_infinity,
    input  logic [GRID_W-1:0]      tank_xpos,
    input  logic [GRID_W-1:0]      tank_ypos,
    input  logic                   offer_valid,
    input  logic [TYPE_W-1:0]      offer_type,
    input  logic [GRID_W-1:0]      offer_xpos,
    input  logic [GRID_W-1:0]      offer_ypos,
    output logic                   offer_taken,
    output logic [NUM_REWARDS-1:0] active,
    output logic                   addtime_pulse,
    input  logic [TYPE_W-1:0]      remain_sel,
    output logic [CNT_W-1:0]       remain_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        TAKEN    = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    localparam logic [CNT_W:0] DUR_EXT = (CNT_W + 1)'(DURATION);

    state_t           state;
    logic [CNT_W-1:0] timer    [NUM_REWARDS];
    logic [CNT_W-1:0] load_val [NUM_REWARDS];
    logic [NUM_REWARDS-1:0] load_en;
    logic             game_step;
    logic             pickup;
    logic             grant_addtime;
    logic [CNT_W-1:0] sel_value;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] v);
        return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] cur);
        logic [CNT_W:0] sum;
        if (STACK_MODE == 0)
            sum = DUR_EXT;
        else
            sum = {1'b0, cur} + DUR_EXT;
        return sat_cnt(sum);
    endfunction

    assign game_step = tick & enable;

    // A reward sitting at row or column 0 is treated as off-map and can never be collected.
    assign pickup = (state == ARMED) && game_step
                 && (offer_xpos != '0) && (offer_ypos != '0)
                 && (tank_xpos == offer_xpos) && (tank_ypos == offer_ypos);

    assign grant_addtime = pickup && mode_infinity && (offer_type == TYPE_W'(1));

    always_comb begin
        load_en = '0;
        for (int k = 0; k < NUM_REWARDS; k++) begin
            load_val[k] = load_value(timer[k]);
            load_en[k]  = pickup && !grant_addtime && (offer_type == TYPE_W'(k + 1));
        end
    end

    always_comb begin
        active = '0;
        for (int k = 0; k < NUM_REWARDS; k++)
            active[k] = (timer[k] != '0);
    end

    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NUM_REWARDS; k++)
            if (remain_sel == TYPE_W'(k + 1))
                sel_value = timer[k];
    end

    // Offer handshake: one pickup per offer, re-armed only after offer_valid is seen low.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state         <= IDLE;
            offer_taken   <= 1'b0;
            addtime_pulse <= 1'b0;
        end else if (enable) begin
            offer_taken   <= 1'b0;
            addtime_pulse <= grant_addtime;
            case (state)
                IDLE: begin
                    if (offer_valid)
                        state <= ARMED;
                end
                ARMED: begin
                    if (pickup) begin
                        state       <= TAKEN;
                        offer_taken <= 1'b1;
                    end else if (!offer_valid) begin
                        state <= IDLE;
                    end
                end
                TAKEN: begin
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!offer_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load on a tick replaces that timer's decrement for the same tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < NUM_REWARDS; k++)
                timer[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REWARDS; k++) begin
                if (load_en[k])
                    timer[k] <= load_val[k];
                else if (game_step && (timer[k] != '0))
                    timer[k] <= timer[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            remain_out <= '0;
        else
            remain_out <= sel_value;
    end

endmodule
